pool_window_sequencer: RTL and testbench
========================================

Name: pool_window_sequencer

Overview:
- Sequences the team's two-input max comparison over non-overlapping POOL x POOL windows of a row-major streamed feature map (max-pool layer).
- Sits between the IFM stream source and the pooled-OFM sink.
- Keeps one partial-max per horizontal window group in an internal row buffer.
- Emits one pooled value per window with valid/ready handshakes.

Parameters:
- DATA_W, 20, element width; unsigned compare.
- POOL, 2, window size = stride; legal range 2..4.
- MAX_W, 224, largest supported feature-map width.
- MAX_H, 224, largest supported feature-map height.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; starts a run using cfg_*.
- cfg_width  in  $clog2(MAX_W+1)  feature-map width W.
- cfg_height  in  $clog2(MAX_H+1)  feature-map height H.
- in_valid  in  1  input element valid.
- in_ready  out  1  input element accepted when in_valid && in_ready.
- in_data  in  DATA_W  input element.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  sink accepts the result.
- out_data  out  DATA_W  pooled result.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of run.
- cfg_err  out  1  one-cycle pulse on rejected start.

Behaviour:
- One clock domain; reset is synchronous and active-high. On rst: state IDLE; all outputs 0 (in_ready, out_valid, out_data, busy, done, cfg_err); counters and accumulators cleared. Row buffer contents are don't-care.
- Reset mid-run aborts immediately. There is no done pulse, and a pending out_valid is dropped.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start with W, H nonzero, W%POOL==0, H%POOL==0, W<=MAX_W, H<=MAX_H: latch cfg, clear col/row, go to RUN, busy=1 next cycle.
  - Otherwise start pulses cfg_err next cycle and stays IDLE.
- start outside IDLE is ignored. No cfg_err, no effect.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational, so no bubbles under full throughput.
- Element accept, per handshake:
  - hacc = (col%POOL==0) ? in_data : max(hacc, in_data).
  - Group result hmax = max(hacc, in_data) at col%POOL==POOL-1, with g = col/POOL:
    - row%POOL==0: buf[g] = hmax.
    - row%POOL in 1..POOL-2: buf[g] = max(buf[g], hmax).
    - row%POOL==POOL-1: out_data = max(buf[g], hmax); out_valid=1 the next cycle (latency 1 from the window's final accept).
- Ties are resolved by either operand; the result value is identical.
- out_valid && !out_ready: out_data and out_valid are held stable. out_valid clears on handshake unless a new result loads in the same cycle (back-to-back allowed).
- col wraps W-1 -> 0 and increments row.
- Accepting the element at (H-1, W-1) moves to DRAIN; in_ready goes low.
- DRAIN: wait until out_valid==0. Then done=1 for one cycle, state IDLE, busy=0 in that same cycle.
- Output count per run = (W/POOL)*(H/POOL), in row-major pooled order.
- Row buffer depth is MAX_W/POOL entries of DATA_W bits. Single read and single write per cycle, same index g.

Decomposition:
- Package pool_pkg:
  - state enum typedef (IDLE, RUN, DRAIN).
  - DATA_W-parametrised max function.
  - Width localparams derived from MAX_W, MAX_H, POOL.
- Sub-module pool_row_buf: synchronous-write, combinational-read partial-max buffer (depth MAX_W/POOL). The FSM, counters and compare logic stay in the top level.

Test Plan:
- W=4, H=4, POOL=2, input 1..16 row-major, out_ready=1 -> outputs 6, 8, 14, 16; done one cycle after the last result; no bubbles on in_ready.
- Same map with out_ready low for 5 cycles after the first result -> out_data holds 6, in_ready=0 during the stall; sequence 6, 8, 14, 16 unchanged; no element lost.
- W=6, H=3, POOL=3, input descending 18..1 -> outputs 18, 15; ties case with all inputs 7 -> outputs 7, 7.
- start with W=5, H=4 (POOL=2), then W=0 -> cfg_err pulse each time; busy stays 0; in_ready stays 0.
- start pulse during RUN -> ignored; run completes with the original 4x4 results.
- rst asserted after 6 accepted elements -> next cycle all outputs 0, state IDLE; a fresh 4x4 run gives 6, 8, 14, 16.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared FSM state type, width helpers and unsigned max for the max-pool sequencer
package pool_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int MAX_DW = 64;
  localparam int PW = 2;
  function automatic int cfg_w(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction
  function automatic int grp_w(input int max_w, input int pool);
    return (max_w / pool) > 1 ? $clog2(max_w / pool) : 1;
  endfunction
  function automatic logic [MAX_DW-1:0] max2(input logic [MAX_DW-1:0] a, input logic [MAX_DW-1:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pool_row_buf.sv
// pool_row_buf: partial-max row buffer with synchronous write and combinational read at one shared index
module pool_row_buf
  import pool_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DEPTH = 112,
  parameter int AW = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (wr_en) mem[idx] <= wr_data;
  assign rd_data = mem[idx];
endmodule

// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer: streams a row-major feature map through non-overlapping POOLxPOOL max-pool windows
module pool_window_sequencer
  import pool_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int POOL = 2,
  parameter int MAX_W = 224,
  parameter int MAX_H = 224
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_W+1)-1:0] cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0] cfg_height,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);
  localparam int WW = cfg_w(MAX_W);
  localparam int HW = cfg_w(MAX_H);
  localparam int DEPTH = MAX_W / POOL;
  localparam int GW = grp_w(MAX_W, POOL);
  localparam logic [PW-1:0] LAST = PW'(POOL - 1);

  state_e state_q, state_d;
  logic [WW-1:0] w_q, w_d, col_q, col_d;
  logic [HW-1:0] h_q, h_d, row_q, row_d;
  logic [PW-1:0] pc_q, pc_d, pr_q, pr_d;
  logic [GW-1:0] g_q, g_d;
  logic [DATA_W-1:0] hacc_q, hacc_d, out_data_q, out_data_d, hmax, rd_data, wr_data;
  logic out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic accept, wr_en, cfg_ok, col_wrap, row_wrap;

  function automatic logic [DATA_W-1:0] mx(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return DATA_W'(max2(MAX_DW'(a), MAX_DW'(b)));
  endfunction

  assign in_ready = state_q == RUN && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  assign hmax = mx(hacc_q, in_data);
  assign col_wrap = col_q == w_q - WW'(1);
  assign row_wrap = row_q == h_q - HW'(1);
  assign wr_en = accept && pc_q == LAST && pr_q != LAST;
  assign wr_data = pr_q == '0 ? hmax : mx(rd_data, hmax);
  assign cfg_ok = cfg_width != '0 && cfg_height != '0 && cfg_width % WW'(POOL) == '0 &&
                  cfg_height % HW'(POOL) == '0 && cfg_width <= WW'(MAX_W) && cfg_height <= HW'(MAX_H);

  pool_row_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(GW)) u_buf (
    .clk(clk),
    .wr_en(wr_en),
    .idx(g_q),
    .wr_data(wr_data),
    .rd_data(rd_data)
  );

  always_comb begin
    state_d = state_q;
    w_d = w_q;
    h_d = h_q;
    col_d = col_q;
    row_d = row_q;
    pc_d = pc_q;
    pr_d = pr_q;
    g_d = g_q;
    hacc_d = hacc_q;
    out_data_d = out_data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cfg_err_d = 1'b0;
    out_valid_d = out_valid_q && !out_ready;
    if (state_q == IDLE && start) begin
      cfg_err_d = !cfg_ok;
      if (cfg_ok) begin
        state_d = RUN;
        busy_d = 1'b1;
        w_d = cfg_width;
        h_d = cfg_height;
        col_d = '0;
        row_d = '0;
        pc_d = '0;
        pr_d = '0;
        g_d = '0;
      end
    end
    if (accept) begin
      hacc_d = pc_q == '0 ? in_data : hmax;
      if (pc_q == LAST && pr_q == LAST) begin
        out_data_d = mx(rd_data, hmax);
        out_valid_d = 1'b1;
      end
      col_d = col_wrap ? '0 : col_q + WW'(1);
      pc_d = pc_q == LAST ? '0 : pc_q + PW'(1);
      g_d = col_wrap ? '0 : g_q + GW'(pc_q == LAST);
      if (col_wrap) begin
        row_d = row_q + HW'(1);
        pr_d = pr_q == LAST ? '0 : pr_q + PW'(1);
        state_d = row_wrap ? DRAIN : RUN;
      end
    end
    if (state_q == DRAIN && !out_valid_d) begin
      state_d = IDLE;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q <= '0;
      h_q <= '0;
      col_q <= '0;
      row_q <= '0;
      pc_q <= '0;
      pr_q <= '0;
      g_q <= '0;
      hacc_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      h_q <= h_d;
      col_q <= col_d;
      row_q <= row_d;
      pc_q <= pc_d;
      pr_q <= pr_d;
      g_q <= g_d;
      hacc_q <= hacc_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_pool_window_sequencer.sv
// tb_pool_window_sequencer: directed checks of the max-pool sequencer at POOL=2 and POOL=3
module tb_pool_window_sequencer;
  localparam int DW = 20;
  logic clk = 1'b0, rst = 1'b1, st2 = 1'b0, st3 = 1'b0, iv = 1'b0, ordy = 1'b1;
  logic [7:0] cw = '0, ch = '0;
  logic [DW-1:0] id = '0;
  logic ir2, ir3, ov2, ov3, busy2, busy3, done2, done3, err2, err3;
  logic [DW-1:0] od2, od3;
  logic ir, ov, busy, done, err;
  logic [DW-1:0] od;
  int sel = 2, cyc = 0, n_chk = 0, n_fail = 0, last_out = 0, done_cyc = 0, done_cnt = 0, acc = 0;
  logic [DW-1:0] got[$];

  always #5 clk = ~clk;

  assign ir = sel == 3 ? ir3 : ir2;
  assign ov = sel == 3 ? ov3 : ov2;
  assign od = sel == 3 ? od3 : od2;
  assign busy = sel == 3 ? busy3 : busy2;
  assign done = sel == 3 ? done3 : done2;
  assign err = sel == 3 ? err3 : err2;

  pool_window_sequencer #(.DATA_W(DW), .POOL(2), .MAX_W(224), .MAX_H(224)) d2 (
    .clk(clk), .rst(rst), .start(st2), .cfg_width(cw), .cfg_height(ch),
    .in_valid(iv), .in_ready(ir2), .in_data(id), .out_valid(ov2), .out_ready(ordy),
    .out_data(od2), .busy(busy2), .done(done2), .cfg_err(err2)
  );

  pool_window_sequencer #(.DATA_W(DW), .POOL(3), .MAX_W(224), .MAX_H(224)) d3 (
    .clk(clk), .rst(rst), .start(st3), .cfg_width(cw), .cfg_height(ch),
    .in_valid(iv), .in_ready(ir3), .in_data(id), .out_valid(ov3), .out_ready(ordy),
    .out_data(od3), .busy(busy3), .done(done3), .cfg_err(err3)
  );

  always @(posedge clk) begin
    if (ov && ordy) begin
      got.push_back(od);
      last_out = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (iv && ir) acc++;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int p, input int w, input int h);
    @(negedge clk);
    sel = p;
    cw = 8'(w);
    ch = 8'(h);
    if (p == 3) st3 = 1'b1;
    else st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0;
    st3 = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] v[$]);
    foreach (v[i]) begin
      int t = 0;
      iv = 1'b1;
      id = v[i];
      do begin
        @(posedge clk);
        t++;
      end while (!ir && t < 100);
      if (!ir) chk("accept_timeout", 32'(ir), 1);
      @(negedge clk);
    end
    iv = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    int t = 0;
    while (done_cnt == prev && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, done_cnt, prev + 1);
    chk({tag, "_pulse_width"}, 32'(done), 0);
    chk({tag, "_busy_low"}, 32'(busy), 0);
  endtask

  task automatic chk_run(input string tag, input int base, input int acc0, input logic [DW-1:0] exp[$], input int n_in);
    chk({tag, "_count"}, got.size() - base, exp.size());
    foreach (exp[i]) if (base + i < got.size()) chk($sformatf("%s_out%0d", tag, i), 32'(got[base + i]), 32'(exp[i]));
    chk({tag, "_accepted"}, acc - acc0, n_in);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(ir), 0);
    chk({tag, "_out_valid"}, 32'(ov), 0);
    chk({tag, "_out_data"}, 32'(od), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cfg_err"}, 32'(err), 0);
  endtask

  initial begin
    logic [DW-1:0] v16[$], vd[$], v7[$], vm[$], v6[$], e4[$], ed[$], e7[$], em[$];
    int b, a, dc, t0, t;
    for (int i = 1; i <= 16; i++) v16.push_back(DW'(i));
    for (int i = 18; i >= 1; i--) vd.push_back(DW'(i));
    for (int i = 0; i < 18; i++) v7.push_back(DW'(7));
    for (int i = 1; i <= 6; i++) v6.push_back(DW'(i));
    vm = {20'd1, 20'd2, 20'd3, 20'd9, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8};
    e4 = {20'd6, 20'd8, 20'd14, 20'd16};
    ed = {20'd18, 20'd15};
    e7 = {20'd7, 20'd7};
    em = {20'd9};

    repeat (3) @(negedge clk);
    sel = 2;
    chk_idle("rst2");
    sel = 3;
    chk_idle("rst3");
    rst = 1'b0;

    b = got.size(); a = acc; dc = done_cnt;
    start_run(2, 4, 4);
    chk("run1_busy", 32'(busy), 1);
    t0 = cyc;
    feed(v16);
    chk("run1_no_bubbles", cyc - t0, 16);
    wait_done("run1_done", dc);
    chk_run("run1", b, a, e4, 16);
    chk("run1_done_latency", done_cyc - last_out, 1);

    b = got.size(); a = acc; dc = done_cnt;
    start_run(2, 4, 4);
    fork
      feed(v16);
      begin
        t = 0;
        while (!ov && t < 100) begin
          @(negedge clk);
          t++;
        end
        ordy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_out_data", 32'(od), 6);
          chk("stall_out_valid", 32'(ov), 1);
          chk("stall_in_ready", 32'(ir), 0);
        end
        ordy = 1'b1;
      end
    join
    wait_done("run2_done", dc);
    chk_run("run2", b, a, e4, 16);

    b = got.size(); a = acc; dc = done_cnt;
    start_run(3, 6, 3);
    feed(vd);
    wait_done("desc_done", dc);
    chk_run("desc", b, a, ed, 18);

    b = got.size(); a = acc; dc = done_cnt;
    start_run(3, 6, 3);
    feed(v7);
    wait_done("ties_done", dc);
    chk_run("ties", b, a, e7, 18);

    b = got.size(); a = acc; dc = done_cnt;
    start_run(3, 3, 3);
    feed(vm);
    wait_done("mid_done", dc);
    chk_run("mid", b, a, em, 9);

    start_run(2, 5, 4);
    chk("err_w5", 32'(err), 1);
    chk("err_w5_busy", 32'(busy), 0);
    chk("err_w5_in_ready", 32'(ir), 0);
    @(negedge clk);
    chk("err_w5_pulse", 32'(err), 0);
    start_run(2, 0, 4);
    chk("err_w0", 32'(err), 1);
    chk("err_w0_busy", 32'(busy), 0);
    chk("err_w0_in_ready", 32'(ir), 0);
    start_run(2, 226, 4);
    chk("err_wmax", 32'(err), 1);
    chk("err_wmax_busy", 32'(busy), 0);

    b = got.size(); a = acc; dc = done_cnt;
    start_run(2, 4, 4);
    fork
      feed(v16);
      begin
        repeat (4) @(negedge clk);
        cw = 8'd2;
        ch = 8'd2;
        st2 = 1'b1;
        @(negedge clk);
        st2 = 1'b0;
        chk("run_start_no_err", 32'(err), 0);
        chk("run_start_busy", 32'(busy), 1);
      end
    join
    wait_done("ign_done", dc);
    chk_run("ign", b, a, e4, 16);

    start_run(2, 4, 4);
    feed(v6);
    chk("pre_rst_valid", 32'(ov), 1);
    chk("pre_rst_data", 32'(od), 6);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("mid_rst");
    dc = done_cnt;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, dc);
    b = got.size(); a = acc;
    start_run(2, 4, 4);
    feed(v16);
    wait_done("post_rst_done", dc);
    chk_run("post_rst", b, a, e4, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
